// File: rtl/multi_cycle_control_fsm.sv
// rtl/multi_cycle_control_fsm.sv - Moore main controller for the multi-cycle RV32I datapath
module multi_cycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [6:0]         i_opcode,
    input  logic               i_zero,
    input  logic               i_mem_ready,
    output logic               o_pc_en,
    output logic               o_adr_src,
    output logic               o_mem_wr,
    output logic               o_ir_wr,
    output logic               o_reg_wr,
    output logic [1:0]         o_res_src,
    output logic [1:0]         o_alu_src_a,
    output logic [1:0]         o_alu_src_b,
    output logic [1:0]         o_alu_ctl,
    output logic [1:0]         o_imm_ctl,
    output logic               o_illegal,
    output logic [STATE_W-1:0] o_state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADR    = 4'd2,
        MEMREAD   = 4'd3,
        MEMWB     = 4'd4,
        MEMWRITE  = 4'd5,
        EXECR     = 4'd6,
        EXECI     = 4'd7,
        ALUWB     = 4'd8,
        BEQ       = 4'd9,
        JAL       = 4'd10,
        JALR      = 4'd11,
        JALR_LINK = 4'd12,
        TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:     if (i_mem_ready) state <= DECODE;
                DECODE: begin
                    case (i_opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECR;
                        OP_I:         state <= EXECI;
                        OP_BEQ:       state <= BEQ;
                        OP_JAL:       state <= JAL;
                        OP_JALR:      state <= JALR;
                        default:      state <= TRAP;
                    endcase
                end
                MEMADR:    state <= (i_opcode == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:   if (i_mem_ready) state <= MEMWB;
                MEMWB:     state <= FETCH;
                MEMWRITE:  if (i_mem_ready) state <= FETCH;
                EXECR:     state <= ALUWB;
                EXECI:     state <= ALUWB;
                ALUWB:     state <= FETCH;
                BEQ:       state <= FETCH;
                JAL:       state <= ALUWB;
                JALR:      state <= JALR_LINK;
                JALR_LINK: state <= FETCH;
                TRAP:      state <= TRAP;
                default:   state <= TRAP;
            endcase
        end
    end

    logic       pc_wr;
    logic       branch;
    logic       adr_src;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic [1:0] res_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctl;
    logic [1:0] imm_ctl;

    always_comb begin
        pc_wr     = 1'b0;
        branch    = 1'b0;
        adr_src   = 1'b0;
        mem_wr    = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        res_src   = 2'b00;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        alu_ctl   = 2'b00;
        case (state)
            FETCH: begin
                alu_src_b = 2'b10;
                res_src   = 2'b10;
                ir_wr     = i_mem_ready;
                pc_wr     = i_mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                res_src = 2'b01;
                reg_wr  = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_wr  = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_ctl   = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctl   = 2'b10;
            end
            ALUWB:    reg_wr = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_ctl   = 2'b01;
                branch    = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_wr     = 1'b1;
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                res_src   = 2'b10;
                pc_wr     = 1'b1;
            end
            // rs1 was already consumed in JALR, so writing rd here is safe even if rd==rs1
            JALR_LINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                res_src   = 2'b10;
                reg_wr    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_opcode)
            OP_I, OP_LW, OP_JALR: imm_ctl = 2'b00;
            OP_SW:                imm_ctl = 2'b01;
            OP_BEQ:               imm_ctl = 2'b10;
            OP_JAL:               imm_ctl = 2'b11;
            default:              imm_ctl = 2'b00;
        endcase
    end

    // Reset gates every output so nothing leaks while the state register is being cleared
    assign o_pc_en     = i_rst_n & (pc_wr | (branch & i_zero));
    assign o_adr_src   = i_rst_n & adr_src;
    assign o_mem_wr    = i_rst_n & mem_wr;
    assign o_ir_wr     = i_rst_n & ir_wr;
    assign o_reg_wr    = i_rst_n & reg_wr;
    assign o_res_src   = i_rst_n ? res_src   : 2'b00;
    assign o_alu_src_a = i_rst_n ? alu_src_a : 2'b00;
    assign o_alu_src_b = i_rst_n ? alu_src_b : 2'b00;
    assign o_alu_ctl   = i_rst_n ? alu_ctl   : 2'b00;
    assign o_imm_ctl   = i_rst_n ? imm_ctl   : 2'b00;
    assign o_illegal   = i_rst_n & (state == TRAP);
    assign o_state     = state;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// tb/tb_multi_cycle_control_fsm.sv - directed self-checking bench for multi_cycle_control_fsm
module tb_multi_cycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, adr_src, mem_wr, ir_wr, reg_wr, illegal;
    logic [1:0] res_src, alu_src_a, alu_src_b, alu_ctl, imm_ctl;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_cycle_control_fsm #(.STATE_W(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_opcode    (opcode),
        .i_zero      (zero),
        .i_mem_ready (mem_ready),
        .o_pc_en     (pc_en),
        .o_adr_src   (adr_src),
        .o_mem_wr    (mem_wr),
        .o_ir_wr     (ir_wr),
        .o_reg_wr    (reg_wr),
        .o_res_src   (res_src),
        .o_alu_src_a (alu_src_a),
        .o_alu_src_b (alu_src_b),
        .o_alu_ctl   (alu_ctl),
        .o_imm_ctl   (imm_ctl),
        .o_illegal   (illegal),
        .o_state     (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {pc_en, adr_src, mem_wr, ir_wr, reg_wr, res_src, alu_src_a, alu_src_b, alu_ctl, imm_ctl}
    function automatic logic [14:0] v(input logic pc, input logic adr, input logic mw, input logic ir,
                                      input logic rw, input logic [1:0] res, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] alu, input logic [1:0] imm);
        return {pc, adr, mw, ir, rw, res, a, b, alu, imm};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {pc_en, adr_src, mem_wr, ir_wr, reg_wr, res_src, alu_src_a, alu_src_b, alu_ctl, imm_ctl};
    endfunction

    // Called just after a falling edge: drive inputs, check, then advance one cycle
    task automatic step(input string tag, input logic rdy, input logic z, input logic [3:0] exp_state,
                        input logic [14:0] exp_vec, input logic exp_ill);
        mem_ready = rdy;
        zero = z;
        #1;
        check({tag, " state"}, {28'd0, state}, {28'd0, exp_state});
        check({tag, " ctl"}, {17'd0, obs_vec()}, {17'd0, exp_vec});
        check({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_decode(input string tag, input logic [6:0] op, input logic [1:0] imm);
        opcode = op;
        step({tag, " fetch"},  1'b1, 1'b1, 4'd0, v(1,0,0,1,0,2'd2,2'd0,2'd2,2'd0,imm), 1'b0);
        step({tag, " decode"}, 1'b1, 1'b1, 4'd1, v(0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,imm), 1'b0);
    endtask

    initial begin
        #1;
        check("rst state", {28'd0, state}, 32'd0);
        check("rst ctl", {17'd0, obs_vec()}, 32'd0);
        check("rst illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        opcode = 7'b0000011;
        for (int i = 0; i < 3; i++)
            step("stall", 1'b0, 1'b0, 4'd0, v(0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,2'd0), 1'b0);

        fetch_decode("lw", 7'b0000011, 2'd0);
        step("lw memadr", 1'b1, 1'b1, 4'd2, v(0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,2'd0), 1'b0);
        step("lw wait1",  1'b0, 1'b1, 4'd3, v(0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0), 1'b0);
        step("lw wait2",  1'b0, 1'b1, 4'd3, v(0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0), 1'b0);
        step("lw read",   1'b1, 1'b1, 4'd3, v(0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0), 1'b0);
        step("lw wb",     1'b1, 1'b1, 4'd4, v(0,0,0,0,1,2'd1,2'd0,2'd0,2'd0,2'd0), 1'b0);

        fetch_decode("sw", 7'b0100011, 2'd1);
        step("sw memadr", 1'b1, 1'b1, 4'd2, v(0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,2'd1), 1'b0);
        step("sw wait",   1'b0, 1'b1, 4'd5, v(0,1,1,0,0,2'd0,2'd0,2'd0,2'd0,2'd1), 1'b0);
        step("sw write",  1'b1, 1'b1, 4'd5, v(0,1,1,0,0,2'd0,2'd0,2'd0,2'd0,2'd1), 1'b0);

        fetch_decode("beq t", 7'b1100011, 2'd2);
        step("beq taken", 1'b1, 1'b1, 4'd9, v(1,0,0,0,0,2'd0,2'd2,2'd0,2'd1,2'd2), 1'b0);
        fetch_decode("beq n", 7'b1100011, 2'd2);
        step("beq not",   1'b1, 1'b0, 4'd9, v(0,0,0,0,0,2'd0,2'd2,2'd0,2'd1,2'd2), 1'b0);

        fetch_decode("r", 7'b0110011, 2'd0);
        step("r exec",  1'b1, 1'b1, 4'd6, v(0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,2'd0), 1'b0);
        step("r wb",    1'b1, 1'b1, 4'd8, v(0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd0), 1'b0);

        fetch_decode("addi", 7'b0010011, 2'd0);
        step("addi exec", 1'b1, 1'b1, 4'd7, v(0,0,0,0,0,2'd0,2'd2,2'd1,2'd2,2'd0), 1'b0);
        step("addi wb",   1'b1, 1'b1, 4'd8, v(0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd0), 1'b0);

        fetch_decode("jal", 7'b1101111, 2'd3);
        step("jal jump", 1'b1, 1'b0, 4'd10, v(1,0,0,0,0,2'd0,2'd1,2'd2,2'd0,2'd3), 1'b0);
        step("jal wb",   1'b1, 1'b1, 4'd8,  v(0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd3), 1'b0);

        fetch_decode("jalr", 7'b1100111, 2'd0);
        step("jalr jump", 1'b1, 1'b0, 4'd11, v(1,0,0,0,0,2'd2,2'd2,2'd1,2'd0,2'd0), 1'b0);
        step("jalr link", 1'b1, 1'b1, 4'd12, v(0,0,0,0,1,2'd2,2'd1,2'd2,2'd0,2'd0), 1'b0);

        // reset in the middle of an lw: must restart cleanly at FETCH
        fetch_decode("lw2", 7'b0000011, 2'd0);
        step("lw2 memadr", 1'b1, 1'b1, 4'd2, v(0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,2'd0), 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst state", {28'd0, state}, 32'd0);
        check("midrst ctl", {17'd0, obs_vec()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("after rst", 1'b0, 1'b1, 4'd0, v(0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,2'd0), 1'b0);

        fetch_decode("ill", 7'b0000000, 2'd0);
        for (int i = 0; i < 10; i++)
            step("trap", 1'b1, 1'b1, 4'd15, v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0), 1'b1);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("trap rst state", {28'd0, state}, 32'd0);
        check("trap rst illegal", {31'd0, illegal}, 32'd0);
        check("trap rst ctl", {17'd0, obs_vec()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("recover", 1'b1, 1'b0, 4'd0, v(1,0,0,1,0,2'd2,2'd0,2'd2,2'd0,2'd0), 1'b0);
        step("recover dec", 1'b1, 1'b0, 4'd1, v(0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd0), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_fsm.md
Name: multi_cycle_control_fsm

Overview:
- Moore-style main controller for the multi-cycle RV32I datapath: a shared instruction/data memory, an IR, OldPC, ALUOut and a Data register.
- Sequences fetch, decode, execute, memory access and writeback for R-type, addi, lw, sw, beq, jal and jalr.
- Handles memory wait states via a ready handshake.
- Traps on unknown opcodes.

Parameters:
- STATE_W, 4, width of the state register and of o_state.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_opcode  in  7  IR[6:0]; valid from DECODE onward.
- i_zero  in  1  ALU zero flag.
- i_mem_ready  in  1  memory completes the current access this cycle.
- o_pc_en  out  1  PC load enable = pc_wr | (branch & i_zero).
- o_adr_src  out  1  memory address mux: 0=PC, 1=ALUOut.
- o_mem_wr  out  1  memory write strobe.
- o_ir_wr  out  1  IR and OldPC load enable.
- o_reg_wr  out  1  register file write enable.
- o_res_src  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult.
- o_alu_src_a  out  2  ALU A mux: 00=PC, 01=OldPC, 10=RD1.
- o_alu_src_b  out  2  ALU B mux: 00=RD2, 01=Imm, 10=const 4.
- o_alu_ctl  out  2  ALU op: 00=add, 01=sub, 10=decode funct3/funct7.
- o_imm_ctl  out  2  immediate format: 00=I, 01=S, 10=B, 11=J.
- o_illegal  out  1  sticky illegal-opcode flag.
- o_state  out  STATE_W  current state, for debug.

Behaviour:
- **State encoding:** FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, JALR=11, JALR_LINK=12, TRAP=15.
- **Reset:**
  - While i_rst_n=0, the state is forced to FETCH immediately.
  - All enables (o_pc_en, o_mem_wr, o_ir_wr, o_reg_wr) are forced to 0.
  - o_illegal=0 and all mux selects are 00.
  - Reset deasserted mid-instruction restarts at FETCH; no partial writes may follow.
- **Unlisted signals:** in any state, every signal not listed for that state is 0 / 00.
- **Immediate format:** o_imm_ctl is decoded from i_opcode in every state. I for 0010011/0000011/1100111, S for 0100011, B for 1100011, J for 1101111, 00 otherwise.
- **FETCH:**
  - Outputs: adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctl=00, res_src=10.
  - ir_wr and pc_wr=1 only when i_mem_ready=1, then go to DECODE.
  - Otherwise hold FETCH with ir_wr=pc_wr=0.
- **DECODE:**
  - Outputs: alu_src_a=01, alu_src_b=01, alu_ctl=00. This computes the branch/jal target into ALUOut.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - 1100111 -> JALR
    - any other opcode -> TRAP
- **MEMADR:** alu_src_a=10, alu_src_b=01, alu_ctl=00. Next is MEMREAD if opcode is lw, MEMWRITE if sw.
- **MEMREAD:** adr_src=1, res_src=00. Hold until i_mem_ready=1, then go to MEMWB.
- **MEMWB:** res_src=01, reg_wr=1, then go to FETCH.
- **MEMWRITE:**
  - adr_src=1, res_src=00, mem_wr=1.
  - mem_wr stays asserted every wait cycle until i_mem_ready=1, then go to FETCH.
- **EXECR:** alu_src_a=10, alu_src_b=00, alu_ctl=10, then go to ALUWB.
- **EXECI:** alu_src_a=10, alu_src_b=01, alu_ctl=10, then go to ALUWB.
- **ALUWB:** res_src=00, reg_wr=1, then go to FETCH.
- **BEQ:**
  - alu_src_a=10, alu_src_b=00, alu_ctl=01, res_src=00, branch=1.
  - o_pc_en = i_zero, combinational in this state only. Then go to FETCH.
- **JAL:**
  - alu_src_a=01, alu_src_b=10, alu_ctl=00, res_src=00, pc_wr=1, then go to ALUWB.
  - PC takes the target; ALUOut takes OldPC+4.
- **JALR:** alu_src_a=10, alu_src_b=01, alu_ctl=00, res_src=10, pc_wr=1, then go to JALR_LINK.
- **JALR_LINK:**
  - alu_src_a=01, alu_src_b=10, alu_ctl=00, res_src=10, reg_wr=1, then go to FETCH.
  - rs1 is consumed before rd is written, so rd==rs1 is safe.
- **TRAP:** all enables 0, o_illegal=1, stay until reset.
- **Cycle counts with zero wait states:**
  - lw 5, sw 4, R/I 4, beq 3, jal 4, jalr 4.
  - Each memory wait cycle adds 1.
- **Gating:** o_pc_en and o_mem_wr are never 1 outside FETCH / MEMWRITE / BEQ / JAL / JALR.

Test Plan:
- **Reset and fetch stall:** reset, i_mem_ready=0 for 3 cycles -> state stays 0, ir_wr=pc_wr=0; ready=1 -> one-cycle ir_wr=1 and o_pc_en=1, next state=1.
- **lw with wait:** opcode 0000011, ready held 1 except 2 wait cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; reg_wr=1 only in state 4 with res_src=01.
- **sw with wait:** opcode 0100011, ready=0 for 1 cycle in MEMWRITE -> mem_wr=1 for exactly 2 cycles, adr_src=1, imm_ctl=01, reg_wr never 1.
- **beq both outcomes:** opcode 1100011 -> with i_zero=1 o_pc_en=1 in BEQ; with i_zero=0 o_pc_en=0; alu_ctl=01 both times; 3 cycles total.
- **jal and jalr:** opcode 1101111 -> states 0,1,10,8,0, o_pc_en in state 10, reg_wr in state 8; opcode 1100111 -> states 0,1,11,12,0, res_src=10 in both 11 and 12.
- **Illegal opcode and recovery:** opcode 0000000 -> TRAP, o_illegal=1 with all enables 0 for 10 cycles; async reset pulse mid-cycle -> state=0 and o_illegal=0 immediately.
